// File: rtl/sdtx_blkseq_if.sv
// Stream handshake bundle between the block sequencer, its word source and the SD transmitter.
// The sequencer sits on the slave side; the source and transmitter drive the master side.
interface sdtx_blkseq_if;
    logic        i_src_valid;
    logic        o_src_ready;
    logic [31:0] i_src_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic [31:0] o_tx_data;
    logic        o_tx_last;
    logic        i_tx_active;

    modport slave (
        input  i_src_valid, i_src_data, i_tx_ready, i_tx_active,
        output o_src_ready, o_tx_valid, o_tx_data, o_tx_last
    );

    modport master (
        output i_src_valid, i_src_data, i_tx_ready, i_tx_active,
        input  o_src_ready, o_tx_valid, o_tx_data, o_tx_last
    );
endinterface

// File: rtl/sdtx_blkseq.sv
// Multi-block SD write sequencer: NAC wait, per-block word streaming, drain of the transmitter,
// inter-block gap and abort handling, with a one-cycle done/err completion pulse.
module sdtx_blkseq #(
    parameter int LGMAXBLK = 11,
    parameter int NW       = 16
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic [NW-1:0] i_nblocks,
    input  logic [3:0]    i_lgblk,
    input  logic [NW-1:0] i_nac,
    input  logic [7:0]    i_gap,
    input  logic          i_abort,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic [NW-1:0] o_blocks_sent,
    output logic          o_tx_en,
    sdtx_blkseq_if.slave  bus
);

    localparam int WW = LGMAXBLK - 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_NAC    = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_GAP    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [NW-1:0] N_ONE = 1;
    localparam logic [WW-1:0] W_ONE = 1;
    localparam logic [WW:0]   B_ONE = 1;

    logic [2:0]    state;
    logic [NW-1:0] nblocks_r;
    logic [3:0]    lgblk_r;
    logic [7:0]    gap_r;
    logic [NW-1:0] nac_cnt;
    logic [7:0]    gap_cnt;
    logic [WW-1:0] word_cnt;
    logic          abort_pend;
    logic          err_r;

    logic          in_stream;
    logic          xfer;
    logic          is_last;
    logic          more_blocks;
    logic          start_bad;
    logic [WW:0]   blk_words;
    logic [WW-1:0] last_idx;

    // Block length is a power of two in 32-bit words, so the final index is words-1.
    always_comb begin
        blk_words   = B_ONE << (lgblk_r - 4'd2);
        last_idx    = WW'(blk_words - B_ONE);
        in_stream   = (state == S_STREAM);
        is_last     = (word_cnt == last_idx);
        xfer        = in_stream && bus.i_src_valid && bus.i_tx_ready;
        more_blocks = ((o_blocks_sent + N_ONE) < nblocks_r);
        start_bad   = (i_nblocks == '0) || (i_lgblk < 4'd2) || (int'(i_lgblk) > LGMAXBLK);

        bus.o_tx_valid  = in_stream && bus.i_src_valid;
        bus.o_src_ready = in_stream && bus.i_tx_ready;
        bus.o_tx_data   = bus.i_src_data;
        bus.o_tx_last   = in_stream && bus.i_src_valid && is_last;

        o_busy  = (state != S_IDLE);
        o_tx_en = (state == S_NAC) || in_stream || (state == S_DRAIN) || (state == S_GAP);
        o_done  = (state == S_DONE) || err_r;
        o_err   = err_r;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= S_IDLE;
            nblocks_r     <= '0;
            lgblk_r       <= 4'd2;
            gap_r         <= '0;
            nac_cnt       <= '0;
            gap_cnt       <= '0;
            word_cnt      <= '0;
            abort_pend    <= 1'b0;
            err_r         <= 1'b0;
            o_blocks_sent <= '0;
        end else begin
            err_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        if (start_bad) begin
                            err_r <= 1'b1;
                        end else begin
                            nblocks_r     <= i_nblocks;
                            lgblk_r       <= i_lgblk;
                            gap_r         <= i_gap;
                            nac_cnt       <= i_nac - N_ONE;
                            word_cnt      <= '0;
                            abort_pend    <= 1'b0;
                            o_blocks_sent <= '0;
                            state         <= (i_nac == '0) ? S_STREAM : S_NAC;
                        end
                    end
                end
                S_NAC: begin
                    if (i_abort) begin
                        state <= S_DONE;
                    end else if (nac_cnt == '0) begin
                        state <= S_STREAM;
                    end else begin
                        nac_cnt <= nac_cnt - N_ONE;
                    end
                end
                // An abort here only marks the transfer to stop once the current block is out.
                S_STREAM: begin
                    if (i_abort) begin
                        abort_pend <= 1'b1;
                    end
                    if (xfer) begin
                        if (is_last) begin
                            word_cnt <= '0;
                            state    <= S_DRAIN;
                        end else begin
                            word_cnt <= word_cnt + W_ONE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (i_abort) begin
                        abort_pend <= 1'b1;
                    end
                    if (!bus.i_tx_active) begin
                        o_blocks_sent <= o_blocks_sent + N_ONE;
                        if (more_blocks && !abort_pend && !i_abort) begin
                            gap_cnt <= (gap_r == 8'd0) ? 8'd0 : gap_r - 8'd1;
                            state   <= S_GAP;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_GAP: begin
                    if (i_abort) begin
                        state <= S_DONE;
                    end else if (gap_cnt == 8'd0) begin
                        word_cnt <= '0;
                        state    <= S_STREAM;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                S_DONE: begin
                    abort_pend <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdtx_blkseq.sv
// Self-checking bench for sdtx_blkseq: directed scenarios plus randomized back-pressure runs,
// each judged against a transaction-level model of words, block boundaries and completion timing.
module tb_sdtx_blkseq;
    localparam int LGMAXBLK = 11;
    localparam int NW       = 16;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_start;
    logic [NW-1:0] i_nblocks;
    logic [3:0]    i_lgblk;
    logic [NW-1:0] i_nac;
    logic [7:0]    i_gap;
    logic          i_abort;
    logic          o_busy;
    logic          o_done;
    logic          o_err;
    logic [NW-1:0] o_blocks_sent;
    logic          o_tx_en;

    sdtx_blkseq_if bus();

    sdtx_blkseq #(.LGMAXBLK(LGMAXBLK), .NW(NW)) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_start       (i_start),
        .i_nblocks     (i_nblocks),
        .i_lgblk       (i_lgblk),
        .i_nac         (i_nac),
        .i_gap         (i_gap),
        .i_abort       (i_abort),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_err         (o_err),
        .o_blocks_sent (o_blocks_sent),
        .o_tx_en       (o_tx_en),
        .bus           (bus)
    );

    always #5 i_clk = ~i_clk;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    int r_nw, r_data_err, r_last_err, r_done_cnt, r_done_cyc, r_blocks_at_done;
    int r_txen_cyc, r_first_valid, r_last_cyc, r_busy_after, r_finished;
    int gap_q[$];
    logic [31:0] exp_words [256];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one whole transfer as the source and transmitter would see it, recording what came out.
    task automatic applyStimulus(input int nb, input int lg, input int nac, input int gap,
                                 input int bp, input int act_len, input int abort_cyc,
                                 input int abort_word, input int busy_start);
        int   w;
        int   act_cnt;
        int   fired_ab;
        int   fired_bs;
        logic xf;
        w = 1 << (lg - 2);
        r_nw = 0; r_data_err = 0; r_last_err = 0; r_done_cnt = 0; r_done_cyc = -10;
        r_blocks_at_done = -1; r_txen_cyc = -1; r_first_valid = -1; r_last_cyc = 0;
        r_busy_after = -1; r_finished = 0;
        gap_q.delete();
        for (int k = 0; k < 256; k++) exp_words[k] = $urandom;
        act_cnt = 0; fired_ab = 0; fired_bs = 0;
        for (int cyc = 0; cyc < 4000 && r_finished == 0; cyc++) begin
            @(negedge i_clk);
            i_start = (cyc == 0);
            if (cyc == 0) begin
                i_nblocks = NW'(nb);
                i_lgblk   = 4'(lg);
                i_nac     = NW'(nac);
                i_gap     = 8'(gap);
            end
            if (busy_start != 0 && fired_bs == 0 && r_nw == 2) begin
                i_start   = 1'b1;
                i_nblocks = 16'd9;
                i_lgblk   = 4'd6;
                i_nac     = 16'd50;
                i_gap     = 8'd200;
                fired_bs  = 1;
            end
            i_abort = (cyc == abort_cyc);
            if (fired_ab == 0 && r_nw == abort_word) begin
                i_abort  = 1'b1;
                fired_ab = 1;
            end
            bus.i_src_valid = (bp != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.i_tx_ready  = (bp != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.i_src_data  = exp_words[r_nw % 256];
            bus.i_tx_active = (act_cnt > 0);
            if (act_cnt > 0) act_cnt--;
            #1;
            if (o_tx_en === 1'b1 && r_txen_cyc < 0) r_txen_cyc = cyc;
            if (bus.o_tx_valid === 1'b1 && r_first_valid < 0) r_first_valid = cyc;
            if (bus.o_tx_valid === 1'b1 && bus.i_src_valid !== 1'b1) r_data_err++;
            xf = bus.o_tx_valid & bus.i_tx_ready;
            if (xf === 1'b1) begin
                if (bus.o_tx_data !== exp_words[r_nw % 256]) r_data_err++;
                if (bus.o_tx_last !== ((r_nw % w) == w - 1)) r_last_err++;
                if (r_nw > 0 && (r_nw % w) == 0) gap_q.push_back(cyc - r_last_cyc);
                if ((r_nw % w) == w - 1) begin
                    r_last_cyc = cyc;
                    act_cnt    = act_len;
                end
                r_nw++;
            end
            if (o_done === 1'b1) begin
                r_done_cnt++;
                r_done_cyc       = cyc;
                r_blocks_at_done = int'(o_blocks_sent);
            end
            if (r_done_cnt > 0 && cyc == r_done_cyc + 1) begin
                r_busy_after = int'(o_busy);
                r_finished   = 1;
            end
        end
        i_start = 1'b0;
        i_abort = 1'b0;
        bus.i_tx_active = 1'b0;
        checkOutput("seq_completed", r_finished, 1);
        if (r_finished == 0) begin
            @(negedge i_clk) i_reset = 1'b1;
            @(negedge i_clk) i_reset = 1'b0;
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_busy"},      o_busy, 0);
        checkOutput({tag, "_done"},      o_done, 0);
        checkOutput({tag, "_err"},       o_err, 0);
        checkOutput({tag, "_blocks"},    o_blocks_sent, 0);
        checkOutput({tag, "_tx_en"},     o_tx_en, 0);
        checkOutput({tag, "_tx_valid"},  bus.o_tx_valid, 0);
        checkOutput({tag, "_src_ready"}, bus.o_src_ready, 0);
        checkOutput({tag, "_tx_last"},   bus.o_tx_last, 0);
    endtask

    initial begin
        int n;
        int busy_seen;
        int nb, lg, words;
        logic [3:0]  bad_lg  [3];
        logic [15:0] bad_nb  [3];
        bad_lg[0] = 4'd1;  bad_nb[0] = 16'd1;
        bad_lg[1] = 4'd4;  bad_nb[1] = 16'd0;
        bad_lg[2] = 4'd12; bad_nb[2] = 16'd2;

        i_reset = 1'b1; i_start = 1'b0; i_abort = 1'b0;
        i_nblocks = '0; i_lgblk = '0; i_nac = '0; i_gap = '0;
        bus.i_src_valid = 1'b1; bus.i_tx_ready = 1'b1;
        bus.i_src_data = 32'hFFFF_FFFF; bus.i_tx_active = 1'b0;
        repeat (3) @(negedge i_clk);
        #1;
        checkIdleOutputs("reset");
        @(negedge i_clk) i_reset = 1'b0;

        // Single 512-byte block after a 5-cycle NAC.
        applyStimulus(1, 9, 5, 0, 0, 4, -1, -1, 0);
        checkOutput("single_txen_cycle",   r_txen_cyc, 1);
        checkOutput("single_first_valid",  r_first_valid, 6);
        checkOutput("single_words",        r_nw, 128);
        checkOutput("single_data_errs",    r_data_err, 0);
        checkOutput("single_last_errs",    r_last_err, 0);
        checkOutput("single_done_cycle",   r_done_cyc, r_last_cyc + 4 + 2);
        checkOutput("single_blocks",       r_blocks_at_done, 1);
        checkOutput("single_busy_after",   r_busy_after, 0);

        // Three 4-word blocks under random back-pressure.
        applyStimulus(3, 4, 2, 0, 1, 1, -1, -1, 0);
        checkOutput("bp_words",     r_nw, 12);
        checkOutput("bp_data_errs", r_data_err, 0);
        checkOutput("bp_last_errs", r_last_err, 0);
        checkOutput("bp_done_cnt",  r_done_cnt, 1);
        checkOutput("bp_blocks",    r_blocks_at_done, 3);

        // Inter-block spacing: drain of act_len active cycles plus one, then max(gap,1).
        applyStimulus(3, 3, 2, 0, 0, 2, -1, -1, 0);
        checkOutput("gap0_count",  gap_q.size(), 2);
        checkOutput("gap0_first",  (gap_q.size() > 0) ? gap_q[0] : -1, 5);
        checkOutput("gap0_second", (gap_q.size() > 1) ? gap_q[1] : -1, 5);
        applyStimulus(2, 3, 0, 3, 0, 2, -1, -1, 0);
        checkOutput("gap3_first",  (gap_q.size() > 0) ? gap_q[0] : -1, 7);
        checkOutput("gap3_blocks", r_blocks_at_done, 2);

        // Illegal requests pulse err+done one cycle later and never leave IDLE.
        for (int t = 0; t < 3; t++) begin
            @(negedge i_clk);
            i_start = 1'b1; i_lgblk = bad_lg[t]; i_nblocks = bad_nb[t]; i_nac = 16'd3;
            @(negedge i_clk);
            i_start = 1'b0;
            #1;
            checkOutput("illegal_err",   o_err, 1);
            checkOutput("illegal_done",  o_done, 1);
            checkOutput("illegal_busy",  o_busy, 0);
            checkOutput("illegal_tx_en", o_tx_en, 0);
            @(negedge i_clk);
            #1;
            checkOutput("illegal_err_clear", o_err, 0);
            checkOutput("illegal_busy_next", o_busy, 0);
        end

        // Abort while waiting out NAC.
        applyStimulus(2, 4, 100, 0, 0, 0, 10, -1, 0);
        checkOutput("abort_nac_done_cycle", r_done_cyc, 11);
        checkOutput("abort_nac_words",      r_nw, 0);
        checkOutput("abort_nac_blocks",     r_blocks_at_done, 0);

        // Abort halfway through block 2 of 4 lets that block finish.
        applyStimulus(4, 4, 1, 0, 0, 1, -1, 6, 0);
        checkOutput("abort_mid_words",     r_nw, 8);
        checkOutput("abort_mid_last_errs", r_last_err, 0);
        checkOutput("abort_mid_blocks",    r_blocks_at_done, 2);

        // Reset after three words of a block.
        @(negedge i_clk);
        i_start = 1'b1; i_nblocks = 16'd1; i_lgblk = 4'd4; i_nac = 16'd0; i_gap = 8'd0;
        bus.i_src_valid = 1'b1; bus.i_tx_ready = 1'b1; bus.i_tx_active = 1'b0;
        n = 0;
        for (int k = 0; k < 50 && n < 3; k++) begin
            @(negedge i_clk);
            i_start = 1'b0;
            #1;
            if (bus.o_tx_valid === 1'b1 && bus.i_tx_ready === 1'b1) n++;
        end
        checkOutput("rst_mid_words_before", n, 3);
        @(negedge i_clk) i_reset = 1'b1;
        @(negedge i_clk) i_reset = 1'b0;
        #1;
        checkIdleOutputs("rst_mid");
        n = 0; busy_seen = 0;
        repeat (5) begin
            @(negedge i_clk);
            #1;
            if (o_done === 1'b1) n++;
            if (o_busy === 1'b1) busy_seen++;
        end
        checkOutput("rst_mid_no_done", n, 0);
        checkOutput("rst_mid_stay_idle", busy_seen, 0);
        applyStimulus(1, 3, 0, 0, 0, 0, -1, -1, 0);
        checkOutput("rst_restart_words",  r_nw, 2);
        checkOutput("rst_restart_blocks", r_blocks_at_done, 1);

        // A second start while busy must not disturb the running transfer.
        applyStimulus(2, 4, 1, 0, 0, 1, -1, -1, 1);
        checkOutput("busy_start_words",     r_nw, 8);
        checkOutput("busy_start_last_errs", r_last_err, 0);
        checkOutput("busy_start_gap",       (gap_q.size() > 0) ? gap_q[0] : -1, 4);
        checkOutput("busy_start_blocks",    r_blocks_at_done, 2);

        // Randomized shapes with random source/transmitter stalls.
        nb = 1;
        for (int it = 0; it < 4; it++) begin
            nb    = $urandom_range(1, 4);
            lg    = $urandom_range(2, 5);
            words = nb * (1 << (lg - 2));
            applyStimulus(nb, lg, $urandom_range(0, 6), $urandom_range(0, 3), 1,
                          $urandom_range(0, 3), -1, -1, 0);
            checkOutput("rand_words",      r_nw, words);
            checkOutput("rand_data_errs",  r_data_err, 0);
            checkOutput("rand_last_errs",  r_last_err, 0);
            checkOutput("rand_done_cnt",   r_done_cnt, 1);
            checkOutput("rand_blocks",     r_blocks_at_done, nb);
            checkOutput("rand_busy_after", r_busy_after, 0);
        end

        // The block count stays visible while idle.
        repeat (3) @(negedge i_clk);
        #1;
        checkOutput("idle_hold_blocks", o_blocks_sent, nb);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
